// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the shared dual-clock FIFO array, write domain.
// Grants one producer per bounded burst and stalls writes whenever full/almost_full is up.
module fifo_wr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int fifo_data_size = 16,
  parameter int MAX_BURST      = 4,
  parameter int CNT_W          = 16
) (
  input  logic                              clk_w,
  input  logic                              rst_w,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*fifo_data_size-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              full,
  input  logic                              almost_full,
  output logic                              w_en,
  output logic [fifo_data_size-1:0]         data_in,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              busy,
  output logic [CNT_W-1:0]                  wr_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [PTR_W:0]   NREQ_EXT  = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(MAX_BURST - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_gidx;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [BC_W-1:0]    r_burst_cnt;
  logic [CNT_W-1:0]   r_wr_count;

  logic               w_blocked;
  logic               w_in_burst;
  logic               w_sel_valid;
  logic               w_accept;
  logic               w_release;
  logic               w_found;
  logic [PTR_W:0]     w_sum;
  logic [PTR_W-1:0]   w_arb_idx;
  logic [NUM_REQ-1:0] w_arb_grant;
  logic [PTR_W-1:0]   w_next_ptr;

  assign w_blocked   = full | almost_full;
  assign w_in_burst  = (r_state == ST_BURST);
  assign w_sel_valid = |(req_valid & r_grant);
  assign w_accept    = w_in_burst & w_sel_valid & ~w_blocked;
  // A blocked cycle never releases, even if the owner has dropped valid.
  assign w_release   = w_in_burst &
                       ((w_accept & (r_burst_cnt == LAST_BEAT)) |
                        (~w_sel_valid & ~w_blocked));

  assign req_ready = (w_in_burst & ~w_blocked) ? r_grant : '0;
  assign w_en      = w_accept;
  assign data_in   = w_accept ? req_data[r_gidx*fifo_data_size +: fifo_data_size] : '0;
  assign grant     = r_grant;
  assign busy      = w_in_burst;
  assign wr_count  = r_wr_count;

  // Search upward from rr_ptr, wrapping modulo NUM_REQ (not modulo 2^PTR_W).
  always_comb begin
    w_found   = 1'b0;
    w_arb_idx = r_rr_ptr;
    w_sum     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
      if (w_sum >= NREQ_EXT) w_sum = w_sum - NREQ_EXT;
      if (!w_found && req_valid[w_sum[PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_arb_idx = w_sum[PTR_W-1:0];
      end
    end
  end

  assign w_arb_grant = NUM_REQ'(1) << w_arb_idx;
  assign w_next_ptr  = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;

  always_ff @(posedge clk_w or negedge rst_w) begin
    if (!rst_w) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_gidx      <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_wr_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state     <= ST_BURST;
            r_grant     <= w_arb_grant;
            r_gidx      <= w_arb_idx;
            r_burst_cnt <= '0;
          end
        end
        default: begin
          if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
            r_wr_count  <= r_wr_count + 1'b1;
          end
          if (w_release) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: an owner/word-count model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;
  localparam int CW = 5;

  logic           clk_w;
  logic           rst_w;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           full;
  logic           almost_full;
  logic           w_en;
  logic [W-1:0]   data_in;
  logic [N-1:0]   grant;
  logic           busy;
  logic [CW-1:0]  wr_count;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .fifo_data_size(W), .MAX_BURST(MB), .CNT_W(CW)
  ) dut (
    .clk_w(clk_w), .rst_w(rst_w), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .full(full), .almost_full(almost_full), .w_en(w_en),
    .data_in(data_in), .grant(grant), .busy(busy), .wr_count(wr_count)
  );

  initial clk_w = 1'b0;
  always #5 clk_w = ~clk_w;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the port, how many words it has written, where the search starts next.
  int m_owner;
  int m_words;
  int m_rr;
  int m_count;
  bit m_blk;
  bit m_wr;
  bit m_found;

  always @(posedge clk_w or negedge rst_w) begin
    if (!rst_w) begin
      m_owner = -1; m_words = 0; m_rr = 0; m_count = 0;
    end else if (m_owner < 0) begin
      m_found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!m_found && req_valid[(m_rr + k) % N]) begin
          m_found = 1'b1;
          m_owner = (m_rr + k) % N;
          m_words = 0;
        end
      end
    end else begin
      m_blk = full | almost_full;
      m_wr  = req_valid[m_owner] && !m_blk;
      if (m_wr) begin
        m_words++;
        m_count = (m_count + 1) % (1 << CW);
      end
      if ((m_wr && m_words == MB) || (!req_valid[m_owner] && !m_blk)) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  logic [N-1:0] e_grant, e_ready;
  logic         e_wen;
  logic [W-1:0] e_data;

  always @(negedge clk_w) begin
    if (chk_en && rst_w) begin
      e_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
      e_wen   = (m_owner >= 0) && !(full | almost_full) && req_valid[m_owner];
      e_ready = ((m_owner >= 0) && !(full | almost_full)) ? e_grant : '0;
      e_data  = e_wen ? req_data[m_owner*W +: W] : '0;
      chk("m_grant", grant, e_grant);
      chk("m_ready", req_ready, e_ready);
      chk("m_wen", w_en, e_wen);
      chk("m_data", data_in, e_data);
      chk("m_busy", busy, m_owner >= 0);
      chk("m_count", wr_count, m_count);
    end
  end

  task automatic tick();
    @(posedge clk_w);
    #1;
  endtask

  task automatic do_reset();
    rst_w = 1'b0;
    #2;
    rst_w = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_w = 1'b0; req_valid = '0; full = 1'b0; almost_full = 1'b0;
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    repeat (2) @(posedge clk_w);
    #1;
    chk("rst_wen", w_en, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_ready", req_ready, 0);
    rst_w = 1'b1;
    chk_en = 1'b1;

    // Single requester: one IDLE cycle, 4 words, release, re-grant
    req_valid = 4'b0001;
    #1;
    chk("t1_idle_wen", w_en, 0);
    tick();
    chk("t1_grant", grant, 4'b0001);
    chk("t1_wen", w_en, 1);
    chk("t1_data", data_in, 16'h1111);
    repeat (4) tick();
    chk("t1_gap_grant", grant, 0);
    chk("t1_count", wr_count, 4);
    tick();
    chk("t1_regrant", grant, 4'b0001);
    req_valid = '0;
    tick();
    chk("t1_release", busy, 0);

    // All requesting: rotation 0,1,2,3,0
    do_reset();
    req_valid = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      tick();
      chk("t2_rr_grant", grant, N'(1) << (b % N));
      if (b < 4) repeat (4) tick();
      if (b == 3) chk("t2_count", wr_count, 16);
    end
    req_valid = '0;
    tick();

    // Stall on almost_full mid-burst (rr now 1)
    req_valid = 4'b0100;
    tick();
    chk("t3_grant", grant, 4'b0100);
    tick();
    tick();
    almost_full = 1'b1;
    repeat (3) begin
      #1;
      chk("t3_stall_wen", w_en, 0);
      chk("t3_stall_ready", req_ready, 0);
      chk("t3_stall_grant", grant, 4'b0100);
      tick();
    end
    almost_full = 1'b0;
    repeat (2) begin
      #1;
      chk("t3_resume_wen", w_en, 1);
      tick();
    end
    chk("t3_release", grant, 0);
    chk("t3_count", wr_count, 20);
    req_valid = '0;

    // Requester 1 drops valid after one word; requester 3 must win next (rr=2)
    req_valid = 4'b0010;
    tick();
    chk("t4_grant1", grant, 4'b0010);
    chk("t4_wen1", w_en, 1);
    req_valid = 4'b1010;
    tick();
    req_valid = 4'b1000;
    #1;
    chk("t4_drop_wen", w_en, 0);
    tick();
    chk("t4_idle", grant, 0);
    req_valid = 4'b1010;
    tick();
    chk("t4_grant3", grant, 4'b1000);
    repeat (4) tick();
    chk("t4_full_burst", grant, 0);
    chk("t4_count", wr_count, 25);
    req_valid = '0;

    // Asynchronous reset during a burst
    req_valid = 4'b0100;
    tick();
    tick();
    tick();
    #1;
    rst_w = 1'b0;
    #1;
    chk("t5_rst_wen", w_en, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_count", wr_count, 0);
    rst_w = 1'b1;
    req_valid = 4'b0110;
    tick();
    chk("t5_lowest", grant, 4'b0010);
    req_valid = '0;
    tick();

    // full held: granted and busy but no writes, then 4 writes
    full = 1'b1;
    req_valid = 4'b0010;
    tick();
    chk("t6_grant", grant, 4'b0010);
    chk("t6_busy", busy, 1);
    repeat (10) begin
      chk("t6_full_wen", w_en, 0);
      tick();
    end
    full = 1'b0;
    repeat (4) begin
      #1;
      chk("t6_wen", w_en, 1);
      tick();
    end
    chk("t6_release", grant, 0);
    chk("t6_count", wr_count, 4);
    req_valid = '0;

    // Counter wrap: 32 more words on a 5-bit counter
    req_valid = 4'b1111;
    repeat (40) tick();
    chk("t7_idle", grant, 0);
    chk("t7_wrap", wr_count, 4);
    req_valid = '0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
